// File: rtl/duc_pkg.sv
// Shared constants, FSM state type and output rounding for the DUC CIC interpolator.
package duc_pkg;

    localparam int unsigned DW      = 16;
    localparam int unsigned N       = 3;
    localparam int unsigned RATE_W  = 13;
    localparam int unsigned IW      = DW + N * RATE_W;
    localparam int unsigned FIFO_D  = 4;
    localparam int unsigned FIFO_AW = $clog2(FIFO_D);
    localparam int unsigned FIFO_CW = FIFO_AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    // Select DW bits at SHIFT and add the bit just below (round half up), wrapping.
    function automatic logic [DW-1:0] round_out(input logic [IW-1:0] acc,
                                                input logic [5:0] shift);
        logic [IW-1:0] w_sh;
        logic [IW-1:0] w_sh1;
        logic          w_rb;
        w_sh  = $signed(acc) >>> shift;
        w_sh1 = acc >> (shift - 6'd1);
        w_rb  = (shift != 6'd0) && w_sh1[0];
        return w_sh[DW-1:0] + {{(DW-1){1'b0}}, w_rb};
    endfunction

endpackage

// File: rtl/cic_interp_lane.sv
// One rail of the CIC interpolator: low-rate comb chain, zero-stuffer, integrator chain.
module cic_interp_lane
    import duc_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_clr,
    input  logic          i_pop,
    input  logic [DW-1:0] i_x,
    output logic [IW-1:0] o_acc
);

    logic [IW-1:0] r_dly   [N];
    logic [IW-1:0] r_integ [N];
    logic [IW-1:0] r_xup;
    logic [IW-1:0] w_comb  [N+1];

    always_comb begin
        w_comb[0] = {{(IW-DW){i_x[DW-1]}}, i_x};
        for (int k = 0; k < N; k++) begin
            w_comb[k+1] = w_comb[k] - r_dly[k];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_xup <= '0;
            for (int k = 0; k < N; k++) begin
                r_dly[k]   <= '0;
                r_integ[k] <= '0;
            end
        end else if (i_clr) begin
            r_xup <= '0;
            for (int k = 0; k < N; k++) begin
                r_dly[k]   <= '0;
                r_integ[k] <= '0;
            end
        end else begin
            // Combs advance only at the low-rate slot; x_up is zero elsewhere.
            if (i_pop) begin
                for (int k = 0; k < N; k++) begin
                    r_dly[k] <= w_comb[k];
                end
                r_xup <= w_comb[N];
            end else begin
                r_xup <= '0;
            end
            r_integ[0] <= r_integ[0] + r_xup;
            for (int k = 1; k < N; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    assign o_acc = r_integ[N-1];

endmodule

// File: rtl/duc_cic_interp.sv
// DUC front end: input I/Q FIFO, phase counter and run FSM around two CIC interpolator lanes.
module duc_cic_interp
    import duc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [RATE_W-1:0] RATE,
    input  logic [5:0]        SHIFT,
    input  logic              IN_VLD,
    output logic              IN_RDY,
    input  logic [DW-1:0]     IN_DATI,
    input  logic [DW-1:0]     IN_DATQ,
    output logic              OUT_DOE,
    output logic [DW-1:0]     OUT_DATI,
    output logic [DW-1:0]     OUT_DATQ,
    output logic              UNDERFLOW
);

    state_t              r_state, w_state_nxt;
    logic [RATE_W-1:0]   r_rate, r_phase;
    logic [FIFO_CW-1:0]  r_count;
    logic [FIFO_AW-1:0]  r_wptr, r_rptr;
    logic [DW-1:0]       r_mem_i [FIFO_D];
    logic [DW-1:0]       r_mem_q [FIFO_D];
    logic [DW-1:0]       r_out_i, r_out_q;
    logic [IW-1:0]       w_acc_i, w_acc_q;
    logic [DW-1:0]       w_x_i, w_x_q;
    logic w_run, w_last, w_slot, w_pop, w_push, w_exit, w_start, w_clr;

    assign w_run   = (r_state == RUN);
    assign w_last  = (r_phase == r_rate - RATE_W'(1));
    assign w_slot  = w_run && (r_phase == '0);
    assign w_pop   = w_slot && (r_count != '0);
    assign IN_RDY  = !RST && (r_count < FIFO_CW'(FIFO_D));
    assign w_push  = IN_VLD && IN_RDY;
    assign w_exit  = w_run && w_last && !EN;
    assign w_start = !w_run && EN && (r_count >= FIFO_CW'(2)) && (RATE >= RATE_W'(2));
    assign w_clr   = !w_run || w_exit;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_start) w_state_nxt = RUN;
            RUN:  if (w_exit)  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_rate  <= '0;
            r_phase <= '0;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_out_i <= '0;
            r_out_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) r_rate <= RATE;
            r_phase <= (!w_run || w_last) ? '0 : r_phase + RATE_W'(1);
            if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CW'(1);
                2'b01:   r_count <= r_count - FIFO_CW'(1);
                default: r_count <= r_count;
            endcase
            r_out_i <= w_clr ? '0 : round_out(w_acc_i, SHIFT);
            r_out_q <= w_clr ? '0 : round_out(w_acc_q, SHIFT);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_i[r_wptr] <= IN_DATI;
            r_mem_q[r_wptr] <= IN_DATQ;
        end
    end

    // An empty pop slot still clocks the combs, with a zero sample.
    assign w_x_i = w_pop ? r_mem_i[r_rptr] : '0;
    assign w_x_q = w_pop ? r_mem_q[r_rptr] : '0;

    cic_interp_lane u_lane_i (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_clr),
        .i_pop (w_slot),
        .i_x   (w_x_i),
        .o_acc (w_acc_i)
    );

    cic_interp_lane u_lane_q (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_clr),
        .i_pop (w_slot),
        .i_x   (w_x_q),
        .o_acc (w_acc_q)
    );

    assign OUT_DOE   = w_run;
    assign OUT_DATI  = r_out_i;
    assign OUT_DATQ  = r_out_q;
    assign UNDERFLOW = w_slot && (r_count == '0);

endmodule

// File: tb/tb_duc_cic_interp.sv
// Directed self-checking bench for duc_cic_interp.
module tb_duc_cic_interp;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [12:0] RATE = 13'd4;
    logic [5:0]  SHIFT = 6'd4;
    logic        IN_VLD = 1'b0;
    logic        IN_RDY;
    logic [15:0] IN_DATI = '0;
    logic [15:0] IN_DATQ = '0;
    logic        OUT_DOE;
    logic [15:0] OUT_DATI, OUT_DATQ;
    logic        UNDERFLOW;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    duc_cic_interp dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .RATE      (RATE),
        .SHIFT     (SHIFT),
        .IN_VLD    (IN_VLD),
        .IN_RDY    (IN_RDY),
        .IN_DATI   (IN_DATI),
        .IN_DATQ   (IN_DATQ),
        .OUT_DOE   (OUT_DOE),
        .OUT_DATI  (OUT_DATI),
        .OUT_DATQ  (OUT_DATQ),
        .UNDERFLOW (UNDERFLOW)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; IN_VLD = 1'b0; IN_DATI = '0; IN_DATQ = '0;
        RATE = 13'd4; SHIFT = 6'd4;
        tick(); tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic push(input int di, input int dq);
        IN_VLD = 1'b1; IN_DATI = 16'(di); IN_DATQ = 16'(dq);
        tick();
        IN_VLD = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        RATE = 13'd4; SHIFT = 6'd2; IN_DATI = 16'd16; IN_DATQ = 16'(-16);
        IN_VLD = 1'b1; EN = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (OUT_DOE !== 1'b1) begin n_err++; $display("FAIL rst_pre_doe: got %b want 1", OUT_DOE); end
        RST = 1'b1; IN_VLD = 1'b0; EN = 1'b0;
        #1;
        n_cmp++;
        if (OUT_DOE !== 1'b0) begin n_err++; $display("FAIL rst_doe: got %b want 0", OUT_DOE); end
        n_cmp++;
        if (OUT_DATI !== 16'd0) begin n_err++; $display("FAIL rst_dati: got %0d want 0", $signed(OUT_DATI)); end
        n_cmp++;
        if (OUT_DATQ !== 16'd0) begin n_err++; $display("FAIL rst_datq: got %0d want 0", $signed(OUT_DATQ)); end
        n_cmp++;
        if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL rst_uf: got %b want 0", UNDERFLOW); end
        n_cmp++;
        if (IN_RDY !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b want 0", IN_RDY); end
        tick();
        RST = 1'b0;
        #1;
        n_cmp++;
        if (IN_RDY !== 1'b1) begin n_err++; $display("FAIL rel_rdy: got %b want 1", IN_RDY); end
        n_cmp++;
        if (OUT_DOE !== 1'b0) begin n_err++; $display("FAIL rel_doe: got %b want 0", OUT_DOE); end
        // FIFO must have been emptied: three pushes leave room, the fourth fills it.
        IN_VLD = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (IN_RDY !== 1'b1) begin n_err++; $display("FAIL rel_rdy3: got %b want 1", IN_RDY); end
        tick();
        IN_VLD = 1'b0;
        n_cmp++;
        if (IN_RDY !== 1'b0) begin n_err++; $display("FAIL rel_rdy4: got %b want 0", IN_RDY); end
    endtask

    task automatic test_dc();
        do_reset();
        RATE = 13'd4; SHIFT = 6'd4; IN_DATI = 16'd100; IN_DATQ = 16'(-100);
        IN_VLD = 1'b1; EN = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            n_cmp++;
            if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL dc_uf[%0d]: got %b want 0", i, UNDERFLOW); end
            if (i >= 50) begin
                n_cmp++;
                if (OUT_DATI !== 16'd100) begin
                    n_err++; $display("FAIL dc_i[%0d]: got %0d want 100", i, $signed(OUT_DATI));
                end
                n_cmp++;
                if (OUT_DATQ !== 16'(-100)) begin
                    n_err++; $display("FAIL dc_q[%0d]: got %0d want -100", i, $signed(OUT_DATQ));
                end
                n_cmp++;
                if (OUT_DOE !== 1'b1) begin n_err++; $display("FAIL dc_doe[%0d]: got %b want 1", i, OUT_DOE); end
            end
        end
        IN_VLD = 1'b0; EN = 1'b0;
    endtask

    task automatic test_impulse();
        int exp_i [10] = '{0, 0, 0, 0, 0, 8, 24, 24, 8, 0};
        int exp_q [10] = '{0, 0, 0, 0, 0, -8, -25, -25, -8, 0};
        do_reset();
        push(16, -17); push(0, 0); push(0, 0); push(0, 0);
        RATE = 13'd2; SHIFT = 6'd1; EN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (OUT_DATI !== 16'(exp_i[k])) begin
                n_err++; $display("FAIL imp_i[%0d]: got %0d want %0d", k, $signed(OUT_DATI), exp_i[k]);
            end
            n_cmp++;
            if (OUT_DATQ !== 16'(exp_q[k])) begin
                n_err++; $display("FAIL imp_q[%0d]: got %0d want %0d", k, $signed(OUT_DATQ), exp_q[k]);
            end
        end
        EN = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        RATE = 13'd4; IN_VLD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IN_DATI = 16'(i + 1); IN_DATQ = 16'(i + 1);
            n_cmp++;
            if (IN_RDY !== 1'b1) begin n_err++; $display("FAIL bp_rdy[%0d]: got %b want 1", i, IN_RDY); end
            tick();
        end
        IN_DATI = 16'd5; IN_DATQ = 16'd5;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (IN_RDY !== 1'b0) begin n_err++; $display("FAIL bp_full[%0d]: got %b want 0", i, IN_RDY); end
            tick();
        end
        EN = 1'b1;
        tick();
        n_cmp++;
        if (IN_RDY !== 1'b0) begin n_err++; $display("FAIL bp_popcyc: got %b want 0", IN_RDY); end
        tick();
        n_cmp++;
        if (IN_RDY !== 1'b1) begin n_err++; $display("FAIL bp_afterpop: got %b want 1", IN_RDY); end
        tick();
        IN_VLD = 1'b0;
        n_cmp++;
        if (IN_RDY !== 1'b0) begin n_err++; $display("FAIL bp_fifth: got %b want 0", IN_RDY); end
        EN = 1'b0;
    endtask

    task automatic test_underflow();
        logic exp_uf;
        do_reset();
        RATE = 13'd4; SHIFT = 6'd4;
        push(64, -64); push(64, -64);
        EN = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            exp_uf = (k >= 8) && (k % 4 == 0);
            n_cmp++;
            if (UNDERFLOW !== exp_uf) begin
                n_err++; $display("FAIL uf[%0d]: got %b want %b", k, UNDERFLOW, exp_uf);
            end
        end
        repeat (40) tick();
        n_cmp++;
        if (OUT_DATI !== 16'd0) begin n_err++; $display("FAIL uf_decay_i: got %0d want 0", $signed(OUT_DATI)); end
        n_cmp++;
        if (OUT_DATQ !== 16'd0) begin n_err++; $display("FAIL uf_decay_q: got %0d want 0", $signed(OUT_DATQ)); end
        n_cmp++;
        if (OUT_DOE !== 1'b1) begin n_err++; $display("FAIL uf_doe: got %b want 1", OUT_DOE); end
        EN = 1'b0;
    endtask

    task automatic test_stop_resume();
        int exp_i [7] = '{0, 0, 0, 0, 0, 200, 600};
        do_reset();
        RATE = 13'd8; SHIFT = 6'd6;
        push(6400, -6400); push(12800, -12800); push(0, 0); push(0, 0);
        EN = 1'b1;
        tick();
        tick();
        EN = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            n_cmp++;
            if (OUT_DOE !== 1'b1) begin n_err++; $display("FAIL stop_doe[%0d]: got %b want 1", k, OUT_DOE); end
            if (k == 6) begin
                n_cmp++;
                if (OUT_DATI !== 16'd100) begin
                    n_err++; $display("FAIL stop_first: got %0d want 100", $signed(OUT_DATI));
                end
            end
            if (k < 8) tick();
        end
        tick();
        n_cmp++;
        if (OUT_DOE !== 1'b0) begin n_err++; $display("FAIL stop_idle_doe: got %b want 0", OUT_DOE); end
        n_cmp++;
        if (OUT_DATI !== 16'd0) begin n_err++; $display("FAIL stop_idle_i: got %0d want 0", $signed(OUT_DATI)); end
        n_cmp++;
        if (OUT_DATQ !== 16'd0) begin n_err++; $display("FAIL stop_idle_q: got %0d want 0", $signed(OUT_DATQ)); end
        n_cmp++;
        if (IN_RDY !== 1'b1) begin n_err++; $display("FAIL stop_rdy3: got %b want 1", IN_RDY); end
        push(0, 0);
        n_cmp++;
        if (IN_RDY !== 1'b0) begin n_err++; $display("FAIL stop_kept: got %b want 0", IN_RDY); end
        EN = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_cmp++;
            if (OUT_DATI !== 16'(exp_i[k])) begin
                n_err++; $display("FAIL resume_i[%0d]: got %0d want %0d", k, $signed(OUT_DATI), exp_i[k]);
            end
            n_cmp++;
            if (OUT_DATQ !== 16'(-exp_i[k])) begin
                n_err++; $display("FAIL resume_q[%0d]: got %0d want %0d", k, $signed(OUT_DATQ), -exp_i[k]);
            end
        end
        EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_back_to_back();
        test_underflow();
        test_stop_resume();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
